// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard: per-register countdown of outstanding multi-cycle loads.
// Optional stall statistics counter is built when HAZARD_STATS_EN is defined.
module hazard_scoreboard #(
  parameter int ADDR_W        = 4,
  parameter int NUM_REGS      = 16,
  parameter int MEM_LAT       = 1,
  parameter int ZERO_REG_HARD = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   ra1_id,
  input  logic                ra1_used,
  input  logic [ADDR_W-1:0]   ra2_id,
  input  logic                ra2_used,
  input  logic [ADDR_W-1:0]   wa_id,
  input  logic                load_id,
  input  logic                valid_id,
  input  logic                hold,
  input  logic                flush,
  output logic                stall,
  output logic [NUM_REGS-1:0] pending
`ifdef HAZARD_STATS_EN
  ,
  input  logic                stats_clr,
  output logic [15:0]         stall_cnt
`endif
);

  localparam int CW   = $clog2(MEM_LAT + 1);
  localparam int SPAN = 1 << ADDR_W;

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAT = cnt_t'(MEM_LAT);

  cnt_t            pend_q [NUM_REGS];
  cnt_t            pend_d [NUM_REGS];
  logic [SPAN-1:0] busy;
  logic            issue;

  // Zero-padded to the full address space so out-of-range reads see "not busy".
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    busy = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      pending[r] = (pend_q[r] != '0);
      busy[r]    = pending[r];
    end
    if (ZERO_REG_HARD != 0) busy[0] = 1'b0;
  end

  assign stall = valid_id & ((ra1_used & busy[ra1_id]) | (ra2_used & busy[ra2_id]));
  assign issue = valid_id & load_id & ~stall & ~hold & ~flush;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) pend_d[r] = pend_q[r];
    if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) pend_d[r] = '0;
    end else if (!hold) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (pend_q[r] != '0) pend_d[r] = pend_q[r] - cnt_t'(1);
        // A reload restarts the countdown rather than stacking on the old one.
        if (issue && (wa_id == ADDR_W'(r)) && !((ZERO_REG_HARD != 0) && (r == 0)))
          pend_d[r] = LAT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the counter array is a handful of flops, not a RAM, so it is reset
      // explicitly; otherwise stale counts would stall after reset release.
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= pend_d[r];
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stats_clr)
      stall_cnt_d = '0;
    else if (stall && !hold && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three configurations share one stimulus stream and
// are checked against a ready-time model of the scoreboard.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ra1, ra2, wa;
  logic        u1, u2, ld, vld, hold, flush;
  logic        stall0, stall1, stall2;
  logic [15:0] pend0, pend1;
  logic [11:0] pend2;
`ifdef HAZARD_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] cnt0, cnt1, cnt2;
`endif

  int errors = 0;
  int checks = 0;

  // Model: each register holds the "effective time" at which its load becomes
  // forwardable; effective time advances on every non-held edge.
  int rdy [3][16];
  int et  [3];
  int m_cnt [3];

  always #5 clk = ~clk;

  hazard_scoreboard #(.ADDR_W(4), .NUM_REGS(16), .MEM_LAT(1), .ZERO_REG_HARD(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .ra1_id(ra1), .ra1_used(u1), .ra2_id(ra2), .ra2_used(u2),
    .wa_id(wa), .load_id(ld), .valid_id(vld), .hold(hold), .flush(flush),
    .stall(stall0), .pending(pend0)
`ifdef HAZARD_STATS_EN
    , .stats_clr(stats_clr), .stall_cnt(cnt0)
`endif
  );

  hazard_scoreboard #(.ADDR_W(4), .NUM_REGS(16), .MEM_LAT(3), .ZERO_REG_HARD(0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .ra1_id(ra1), .ra1_used(u1), .ra2_id(ra2), .ra2_used(u2),
    .wa_id(wa), .load_id(ld), .valid_id(vld), .hold(hold), .flush(flush),
    .stall(stall1), .pending(pend1)
`ifdef HAZARD_STATS_EN
    , .stats_clr(stats_clr), .stall_cnt(cnt1)
`endif
  );

  hazard_scoreboard #(.ADDR_W(4), .NUM_REGS(12), .MEM_LAT(2), .ZERO_REG_HARD(1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .ra1_id(ra1), .ra1_used(u1), .ra2_id(ra2), .ra2_used(u2),
    .wa_id(wa), .load_id(ld), .valid_id(vld), .hold(hold), .flush(flush),
    .stall(stall2), .pending(pend2)
`ifdef HAZARD_STATS_EN
    , .stats_clr(stats_clr), .stall_cnt(cnt2)
`endif
  );

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 2);
  endfunction

  function automatic int nregs_of(int d);
    return (d == 2) ? 12 : 16;
  endfunction

  function automatic bit zrh_of(int d);
    return (d == 2);
  endfunction

  function automatic bit m_busy(int d, logic [3:0] a);
    if (int'(a) >= nregs_of(d)) return 1'b0;
    if (zrh_of(d) && a == 4'd0) return 1'b0;
    return rdy[d][a] > et[d];
  endfunction

  function automatic bit m_stall(int d);
    return vld && ((u1 && m_busy(d, ra1)) || (u2 && m_busy(d, ra2)));
  endfunction

  function automatic logic [15:0] m_pend(int d);
    logic [15:0] p = '0;
    for (int r = 0; r < nregs_of(d); r++) p[r] = (rdy[d][r] > et[d]);
    return p;
  endfunction

  function automatic logic dut_stall(int d);
    return (d == 0) ? stall0 : ((d == 1) ? stall1 : stall2);
  endfunction

  function automatic logic [15:0] dut_pend(int d);
    return (d == 0) ? pend0 : ((d == 1) ? pend1 : {4'h0, pend2});
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      et[d] = 0;
      m_cnt[d] = 0;
      for (int r = 0; r < 16; r++) rdy[d][r] = 0;
    end
  endtask

  task automatic set_idle();
    ra1 = 4'd0; ra2 = 4'd0; wa = 4'd0;
    u1 = 1'b0; u2 = 1'b0; ld = 1'b0; vld = 1'b0; hold = 1'b0; flush = 1'b0;
  endtask

  // Advance the model by one edge using the inputs currently applied, then clock the DUTs.
  task automatic tick();
    bit st [3];
    bit iss;
    for (int d = 0; d < 3; d++) st[d] = m_stall(d);
    for (int d = 0; d < 3; d++) begin
`ifdef HAZARD_STATS_EN
      if (stats_clr) m_cnt[d] = 0;
      else if (st[d] && !hold && m_cnt[d] < 65535) m_cnt[d]++;
`endif
      iss = vld && ld && !st[d] && !hold && !flush;
      if (flush) begin
        for (int r = 0; r < 16; r++) rdy[d][r] = 0;
      end else if (!hold) begin
        et[d]++;
        if (iss && int'(wa) < nregs_of(d) && !(zrh_of(d) && wa == 4'd0))
          rdy[d][wa] = et[d] + lat_of(d);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    set_idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    vld = 1'b1; u1 = 1'b1; ra1 = 4'd1;
    #3;
    checks++;
    if ({stall0, stall1, stall2} !== 3'b000) begin
      errors++; $display("FAIL reset_stall: got %b want 000", {stall0, stall1, stall2});
    end
    checks++;
    if ({pend0, pend1, pend2} !== 44'h0) begin
      errors++; $display("FAIL reset_pending: got %h want 0", {pend0, pend1, pend2});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_only();
    clear_all();
    for (int i = 0; i < 4; i++) begin
      vld = 1'b1; ld = 1'b0; u1 = 1'b1; ra1 = 4'd1; wa = 4'd1;
      @(negedge clk);
      checks++;
      if (stall0 !== 1'b0) begin errors++; $display("FAIL alu_only_stall: got %b want 0", stall0); end
      checks++;
      if (pend0 !== 16'h0) begin errors++; $display("FAIL alu_only_pending: got %h want 0000", pend0); end
      tick();
    end
  endtask

  task automatic test_load_use_l1();
    clear_all();
    vld = 1'b1; ld = 1'b1; wa = 4'd1;
    @(negedge clk);
    checks++;
    if (stall0 !== 1'b0) begin errors++; $display("FAIL l1_load_stall: got %b want 0", stall0); end
    tick();
    ld = 1'b0; u1 = 1'b1; ra1 = 4'd1; wa = 4'd7;
    @(negedge clk);
    checks++;
    if (stall0 !== 1'b1) begin errors++; $display("FAIL l1_use_stall: got %b want 1", stall0); end
    checks++;
    if (pend0 !== 16'h0002) begin errors++; $display("FAIL l1_use_pending: got %h want 0002", pend0); end
    tick();
    @(negedge clk);
    checks++;
    if (stall0 !== 1'b0) begin errors++; $display("FAIL l1_release_stall: got %b want 0", stall0); end
    checks++;
    if (pend0 !== 16'h0) begin errors++; $display("FAIL l1_release_pending: got %h want 0000", pend0); end
    tick();
  endtask

  task automatic test_load_use_l3();
    int n = 0;
    clear_all();
    vld = 1'b1; ld = 1'b1; wa = 4'd2;
    tick();
    ld = 1'b0; u2 = 1'b1; ra2 = 4'd2; wa = 4'd9;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stall1) break;
      n++;
      tick();
    end
    checks++;
    if (n !== 3) begin errors++; $display("FAIL l3_stall_cycles: got %0d want 3", n); end
    tick();
    ld = 1'b1; u2 = 1'b0; wa = 4'd2;
    tick();
    ld = 1'b0; u1 = 1'b1; ra1 = 4'd5; wa = 4'd9;
    @(negedge clk);
    checks++;
    if (stall1 !== 1'b0) begin errors++; $display("FAIL l3_independent_stall: got %b want 0", stall1); end
    checks++;
    if (pend1 !== 16'h0004) begin errors++; $display("FAIL l3_independent_pending: got %h want 0004", pend1); end
    tick();
  endtask

  task automatic test_hold();
    int n = 0;
    clear_all();
    vld = 1'b1; ld = 1'b1; wa = 4'd4;
    tick();
    ld = 1'b0; u1 = 1'b1; ra1 = 4'd4; wa = 4'd9;
    for (int i = 0; i < 20; i++) begin
      hold = (i == 1 || i == 2);
      @(negedge clk);
      if (!stall1) break;
      if (hold) begin
        checks++;
        if (pend1[4] !== 1'b1) begin errors++; $display("FAIL hold_pending4: got %b want 1", pend1[4]); end
      end
      n++;
      tick();
    end
    hold = 1'b0;
    checks++;
    if (n !== 5) begin errors++; $display("FAIL hold_stall_cycles: got %0d want 5", n); end
    tick();
  endtask

  task automatic test_flush();
    clear_all();
    vld = 1'b1; ld = 1'b1; wa = 4'd3;
    @(negedge clk);
    checks++;
    if (stall2 !== 1'b0) begin errors++; $display("FAIL flush_load_stall: got %b want 0", stall2); end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; ld = 1'b0; u1 = 1'b1; ra1 = 4'd3; wa = 4'd9;
    @(negedge clk);
    checks++;
    if (pend2 !== 12'h0) begin errors++; $display("FAIL flush_pending: got %h want 000", pend2); end
    checks++;
    if (stall2 !== 1'b0) begin errors++; $display("FAIL flush_read_stall: got %b want 0", stall2); end
    tick();
  endtask

  task automatic test_zero_and_range();
    clear_all();
`ifdef HAZARD_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
`endif
    vld = 1'b1; ld = 1'b1; wa = 4'd0;
    tick();
    ld = 1'b0; u1 = 1'b1; ra1 = 4'd0; wa = 4'd9;
    @(negedge clk);
    checks++;
    if (stall2 !== 1'b0) begin errors++; $display("FAIL zero_reg_stall: got %b want 0", stall2); end
    checks++;
    if (pend2 !== 12'h0) begin errors++; $display("FAIL zero_reg_pending: got %h want 000", pend2); end
    tick();
`ifdef HAZARD_STATS_EN
    checks++;
    if (cnt2 !== 16'd0) begin errors++; $display("FAIL zero_reg_stall_cnt: got %0d want 0", cnt2); end
`endif
    clear_all();
    vld = 1'b1; ld = 1'b1; wa = 4'd13;
    tick();
    ld = 1'b0; u1 = 1'b1; ra1 = 4'd13; wa = 4'd9;
    @(negedge clk);
    checks++;
    if (stall2 !== 1'b0) begin errors++; $display("FAIL out_of_range_stall: got %b want 0", stall2); end
    tick();
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    clear_all();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    for (int p = 0; p < 4; p++) begin
      set_idle();
      vld = 1'b1; ld = 1'b1; wa = 4'd5;
      tick();
      ld = 1'b0; u1 = 1'b1; ra1 = 4'd5; wa = 4'd9;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!stall2) break;
        tick();
      end
      tick();
    end
    checks++;
    if (cnt2 !== 16'd8) begin errors++; $display("FAIL stats_count: got %0d want 8", cnt2); end
    set_idle();
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    checks++;
    if (cnt2 !== 16'd0) begin errors++; $display("FAIL stats_clear: got %0d want 0", cnt2); end
  endtask
`endif

  task automatic test_async_reset();
    clear_all();
    vld = 1'b1; ld = 1'b1; wa = 4'd2;
    tick();
    ld = 1'b0; u1 = 1'b1; ra1 = 4'd2; wa = 4'd9;
    @(negedge clk);
    checks++;
    if (stall1 !== 1'b1) begin errors++; $display("FAIL arst_pre_stall: got %b want 1", stall1); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({stall0, stall1, stall2} !== 3'b000) begin
      errors++; $display("FAIL arst_stall: got %b want 000", {stall0, stall1, stall2});
    end
    checks++;
    if (pend1 !== 16'h0) begin errors++; $display("FAIL arst_pending: got %h want 0000", pend1); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (stall1 !== 1'b0) begin errors++; $display("FAIL arst_release_stall: got %b want 0", stall1); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      vld   = ($urandom_range(0, 7) != 0);
      ld    = ($urandom_range(0, 2) == 0);
      u1    = $urandom_range(0, 1);
      u2    = $urandom_range(0, 1);
      ra1   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
      ra2   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
      wa    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
      hold  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
`ifdef HAZARD_STATS_EN
      stats_clr = ($urandom_range(0, 31) == 0);
`endif
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (dut_stall(d) !== m_stall(d)) begin
          errors++; $display("FAIL rand_stall d%0d cyc%0d: got %b want %b", d, c, dut_stall(d), m_stall(d));
        end
        checks++;
        if (dut_pend(d) !== m_pend(d)) begin
          errors++; $display("FAIL rand_pending d%0d cyc%0d: got %h want %h", d, c, dut_pend(d), m_pend(d));
        end
      end
`ifdef HAZARD_STATS_EN
      checks++;
      if ({cnt0, cnt1, cnt2} !== {16'(m_cnt[0]), 16'(m_cnt[1]), 16'(m_cnt[2])}) begin
        errors++; $display("FAIL rand_stall_cnt cyc%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                           c, cnt0, cnt1, cnt2, m_cnt[0], m_cnt[1], m_cnt[2]);
      end
`endif
      tick();
    end
`ifdef HAZARD_STATS_EN
    stats_clr = 1'b0;
`endif
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    model_reset();
    test_reset();
    test_alu_only();
    test_load_use_l1();
    test_load_use_l3();
    test_hold();
    test_flush();
    test_zero_and_range();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
